// File: rtl/seq_modarith_unit.sv
// -----------------------------------------------------------------------------
// seq_modarith_unit
//   Multi-cycle modular-arithmetic engine. One operation per start/done
//   transaction: MOD, GCD, MODMUL, MODEXP, FERMAT. Division (restoring) and
//   multiplication (Blakley interleaved) advance one bit per clock, so no wide
//   combinational divider or multiplier is built.
//
// Ports
//   clk     in   clock, all state updates on posedge
//   rst     in   asynchronous active-high reset
//   start   in   request, sampled only while busy=0
//   op      in   0=MOD 1=GCD 2=MODMUL 3=MODEXP 4=FERMAT, 5-7 illegal
//   a       in   operand A (base for MODEXP/FERMAT)
//   b       in   operand B (exponent for MODEXP)
//   m       in   modulus (unused by GCD)
//   busy    out  operation in flight
//   done    out  one-cycle pulse, result/err valid in that cycle
//   err     out  illegal op or invalid modulus, held until next accept
//   result  out  result, held until the next operation completes
// -----------------------------------------------------------------------------
module seq_modarith_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_MOD    = 3'd0;
    localparam logic [2:0] OP_GCD    = 3'd1;
    localparam logic [2:0] OP_MODMUL = 3'd2;
    localparam logic [2:0] OP_FERMAT = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_RED, S_GCD, S_MM, S_EXPCTL, S_FIN
    } state_t;

    state_t state, state_nxt;

    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, m_q;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] dq, ar;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mm_acc, mm_x, mm_y;
    logic [WIDTH-1:0] e_q;
    logic [CW-1:0]    ebits;
    logic             mul_ph;
    logic [WIDTH-1:0] u, v;
    logic [CW-1:0]    k;
    logic             gcd_loop;

    // Subtract the modulus once if the value is not already reduced.
    function automatic logic [WIDTH:0] cond_sub(input logic [WIDTH:0] t,
                                                input logic [WIDTH-1:0] md);
        return (t >= {1'b0, md}) ? t - {1'b0, md} : t;
    endfunction

    // One Blakley step: acc' = (2*acc + ybit*x) mod md, with acc, x < md.
    function automatic logic [WIDTH-1:0] blakley_step(input logic [WIDTH-1:0] acc,
                                                      input logic [WIDTH-1:0] x,
                                                      input logic             ybit,
                                                      input logic [WIDTH-1:0] md);
        logic [WIDTH:0] t;
        t = cond_sub({acc, 1'b0}, md);
        if (ybit)
            t = t + {1'b0, x};
        t = cond_sub(t, md);
        return t[WIDTH-1:0];
    endfunction

    logic             accept, chk_err, cnt_last, exp_fin, gcd_fin;
    logic [WIDTH:0]   rem_nxt;
    logic [WIDTH-1:0] mm_res, ar_nxt, exp_one;

    assign accept   = start && (state == S_IDLE || state == S_FIN);
    assign chk_err  = (op_q > OP_FERMAT) ||
                      (op_q != OP_GCD && m_q == '0) ||
                      (op_q == OP_FERMAT && m_q < WIDTH'(2));
    assign cnt_last = (cnt == CW'(WIDTH - 1));
    // Partial remainder shifted left with the next dividend bit brought in.
    assign rem_nxt  = cond_sub((rem << 1) | {{WIDTH{1'b0}}, dq[WIDTH-1]}, m_q);
    assign ar_nxt   = rem_nxt[WIDTH-1:0];
    assign mm_res   = blakley_step(mm_acc, mm_x, mm_y[WIDTH-1], m_q);
    assign exp_one  = (m_q == WIDTH'(1)) ? '0 : WIDTH'(1);
    // An exponent bit is complete after its square (bit=0) or its multiply.
    assign exp_fin  = (mul_ph || !e_q[WIDTH-1]) && (ebits == CW'(1));
    assign gcd_fin  = (!gcd_loop && (u == '0 || v == '0)) || (gcd_loop && v == '0);

    assign busy = (state != S_IDLE) && (state != S_FIN);
    assign done = (state == S_FIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_CHECK;
            S_CHECK: begin
                if (chk_err)             state_nxt = S_FIN;
                else if (op_q == OP_GCD) state_nxt = S_GCD;
                else                     state_nxt = S_RED;
            end
            S_RED: begin
                if (cnt_last) begin
                    if (op_q == OP_MOD)         state_nxt = S_FIN;
                    else if (op_q == OP_MODMUL) state_nxt = S_MM;
                    else                        state_nxt = S_EXPCTL;
                end
            end
            S_MM:     if (cnt_last) state_nxt = S_FIN;
            S_EXPCTL: if (cnt_last && exp_fin) state_nxt = S_FIN;
            S_GCD:    if (gcd_fin) state_nxt = S_FIN;
            S_FIN:    state_nxt = start ? S_CHECK : S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= '0; a_q <= '0; b_q <= '0; m_q <= '0;
            rem <= '0; dq <= '0; ar <= '0; cnt <= '0;
            mm_acc <= '0; mm_x <= '0; mm_y <= '0;
            e_q <= '0; ebits <= '0; mul_ph <= 1'b0;
            u <= '0; v <= '0; k <= '0; gcd_loop <= 1'b0;
            err <= 1'b0; result <= '0;
        end else begin
            if (accept) begin
                op_q <= op; a_q <= a; b_q <= b; m_q <= m;
                err  <= 1'b0;
            end
            case (state)
                S_CHECK: begin
                    cnt <= '0; rem <= '0; dq <= a_q;
                    u <= a_q; v <= b_q; k <= '0; gcd_loop <= 1'b0;
                    if (chk_err) begin
                        err    <= 1'b1;
                        result <= '0;
                    end
                end
                S_RED: begin
                    rem <= rem_nxt;
                    dq  <= dq << 1;
                    cnt <= cnt + CW'(1);
                    if (cnt_last) begin
                        ar     <= ar_nxt;
                        cnt    <= '0;
                        mm_acc <= '0;
                        mul_ph <= 1'b0;
                        if (op_q == OP_MOD) begin
                            result <= ar_nxt;
                        end else if (op_q == OP_MODMUL) begin
                            mm_x <= ar_nxt;
                            mm_y <= b_q;
                        end else begin
                            // First pass squares acc = 1 mod m; leading zeros still cost a square.
                            mm_x  <= exp_one;
                            mm_y  <= exp_one;
                            e_q   <= (op_q == OP_FERMAT) ? m_q - WIDTH'(1) : b_q;
                            ebits <= CW'(WIDTH);
                        end
                    end
                end
                S_MM: begin
                    mm_acc <= mm_res;
                    mm_y   <= mm_y << 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt_last)
                        result <= mm_res;
                end
                S_EXPCTL: begin
                    mm_acc <= mm_res;
                    mm_y   <= mm_y << 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt_last) begin
                        cnt    <= '0;
                        mm_acc <= '0;
                        mm_x   <= mm_res;
                        if (!mul_ph && e_q[WIDTH-1]) begin
                            mul_ph <= 1'b1;
                            mm_y   <= ar;
                        end else begin
                            mul_ph <= 1'b0;
                            mm_y   <= mm_res;
                            e_q    <= e_q << 1;
                            ebits  <= ebits - CW'(1);
                            if (exp_fin)
                                result <= (op_q == OP_FERMAT) ?
                                          {{(WIDTH-1){1'b0}}, (mm_res == WIDTH'(1))} : mm_res;
                        end
                    end
                end
                S_GCD: begin
                    if (gcd_fin) begin
                        // One of u/v is zero (or v is zero in the loop), so u|v is the odd gcd part.
                        result <= (u | v) << k;
                    end else if (!gcd_loop) begin
                        if (!u[0] && !v[0]) begin
                            u <= u >> 1;
                            v <= v >> 1;
                            k <= k + CW'(1);
                        end else if (!u[0]) begin
                            u <= u >> 1;
                        end else begin
                            gcd_loop <= 1'b1;
                        end
                    end else begin
                        // u stays odd; swap and subtract are folded into one step.
                        if (!v[0]) begin
                            v <= v >> 1;
                        end else if (u > v) begin
                            u <= v;
                            v <= u - v;
                        end else begin
                            v <= v - u;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
